seg7_scan_decoder: RTL and testbench
====================================

# seg7_scan_decoder

Recovers displayed hex digits from the multiplexed common-anode seven-segment drive of the Morning Clock display. It sits on the display side of the segment encoder and reads the active-low segment pins plus the active-low digit selects. It waits for each scanned digit to settle, decodes the segment pattern back to a 4-bit value, and keeps a per-digit register file. The clock-self-test logic and the debug UART read these registers.

## Interface
- DIGITS, 4: number of multiplexed digit positions; range 1..8.
- STABLE_CYCLES, 8: consecutive identical synchronized samples required before capture; minimum 2.
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- Pin_a … Pin_g, Pin_dp  in  1 each  segment drive; active-low, so 0 means the segment is lit.
- dig_sel_n  in  DIGITS  digit select; active-low; a valid scan slot has exactly one bit low.
- digit_value  out  4*DIGITS  decoded value; digit i is in bits [4i+3:4i].
- digit_dp  out  DIGITS  1 when the decimal point was lit at capture.
- digit_valid  out  DIGITS  sticky; set by the first capture of that digit.
- digit_err  out  DIGITS  1 when the last captured pattern is not a hex glyph.
- update  out  1  one-cycle pulse on every capture.
- update_idx  out  3  index of the digit written. Meaningful only while update is high.

## Operation
- Input synchronizer:
  - Two flops on all segment pins and selects.
  - S is the synchronized vector {a,b,c,d,e,f,g,dp,dig_sel_n}.
- Decode works on lit = ~{a..g}, MSB first (a first). Lit pattern to value:
  - 0: 7E, 1: 30, 2: 6D, 3: 79, 4: 33
  - 5: 5B, 6: 5F, 7: 70, 8: 7F, 9: 7B
  - A: 77, b: 1F, C: 4E, d: 3D, E: 4F, F: 47
  - Any other pattern, including blank 00 and "H" 37, sets err=1 and value=0.
- dp bit: stored as ~Pin_dp.
- FSM states are WAIT, SETTLE, HOLD.
  - WAIT: when S has exactly one select low, latch ref=S and cnt=1, then go to SETTLE. Otherwise stay.
  - SETTLE, S==ref: cnt increments.
    - When cnt reaches STABLE_CYCLES, capture on that edge and go to HOLD.
  - SETTLE or HOLD, S!=ref: apply the WAIT evaluation in the same cycle.
    - A new one-hot S restarts SETTLE with cnt=1.
    - Anything else goes to WAIT.
  - HOLD, S==ref: stay. No repeat capture while the pattern is static.
- Capture of the selected digit i writes:
  - digit_value[i]
  - digit_err[i]
  - digit_dp[i]
  - digit_valid[i]=1
  - update=1, update_idx=i
- Other digits are untouched.
- Invalid select vectors (zero bits low, or several bits low) never capture and never increment cnt.
- cnt width is clog2(STABLE_CYCLES+1). It saturates at STABLE_CYCLES and never wraps.

## Timing
- Reset: FSM=WAIT, cnt=0, and every output is 0 (digit_value, dp, valid, err, update, update_idx). Deassertion is released synchronously through the FSM.
- Reset asserted mid-SETTLE or mid-HOLD: clears all stored digits at once, and no capture completes.
- Latency: edge 0 is the first edge on which a new stable pin state is sampled.
  - S is valid after edge 1.
  - SETTLE cnt=1 after edge 2.
  - Capture happens at edge STABLE_CYCLES+1.
  - With STABLE_CYCLES=8, update is high in the cycle after edge 9.
- Any change of any synchronized bit before capture restarts the count; the glitch never captures.
- update is high for exactly one cycle per capture.
- Back-to-back captures are at least STABLE_CYCLES cycles apart.
- Selects moving from digit i to digit j with unchanged segments: counts as a change, so digit j is captured after a full settle.
- Segment change and select change on the same edge: a single restart.

## Test plan
- Reset then idle with dig_sel_n=1111 → all outputs 0, no update for 100 cycles.
- Drive dig_sel_n=1110, lit=5B, Pin_dp=0, held 20 cycles → update once at the 10th edge, update_idx=0, digit_value[3:0]=5, digit_dp[0]=1, valid[0]=1, err[0]=0.
- Scan digits 0..3 with 1,2,3,4 (30,6D,79,33), 16 cycles each, repeated twice → digit_value=16'h4321, all valid, exactly 8 update pulses.
- Pattern 5B held 5 cycles, then a 1-cycle flip of Pin_g, then held 20 cycles → no capture before the glitch; a single capture 10 edges after the glitch clears.
- lit=37 ("H") on digit 2 → err[2]=1, digit_value[11:8]=0, valid[2]=1. dig_sel_n=1100 for 30 cycles → no update.
- Assert rst_n=0 at cnt=5 during SETTLE after prior captures → all outputs 0 immediately, and the next capture needs a full 10 edges after release.

Source files
------------

// File: rtl/seg7_scan_decoder_if.sv
// Bundle of the multiplexed seven-segment pins and the decoded per-digit results.
//   master : the display drive side (drives segment/select pins, observes results)
//   slave  : the decoder (samples pins, drives results)
// Signals:
//   Pin_a..Pin_g, Pin_dp  active-low segment drive
//   dig_sel_n             active-low digit select, one bit low per valid scan slot
//   digit_value           decoded nibble per digit, digit i at [4i+3:4i]
//   digit_dp              decimal point lit at capture
//   digit_valid           sticky, set by first capture of the digit
//   digit_err             last captured pattern was not a hex glyph
//   update / update_idx   one-cycle capture pulse and the digit it wrote
interface seg7_scan_decoder_if #(
  parameter int DIGITS = 4
);
  logic                  Pin_a;
  logic                  Pin_b;
  logic                  Pin_c;
  logic                  Pin_d;
  logic                  Pin_e;
  logic                  Pin_f;
  logic                  Pin_g;
  logic                  Pin_dp;
  logic [DIGITS-1:0]     dig_sel_n;
  logic [4*DIGITS-1:0]   digit_value;
  logic [DIGITS-1:0]     digit_dp;
  logic [DIGITS-1:0]     digit_valid;
  logic [DIGITS-1:0]     digit_err;
  logic                  update;
  logic [2:0]            update_idx;

  modport master (
    output Pin_a, Pin_b, Pin_c, Pin_d, Pin_e, Pin_f, Pin_g, Pin_dp, dig_sel_n,
    input  digit_value, digit_dp, digit_valid, digit_err, update, update_idx
  );

  modport slave (
    input  Pin_a, Pin_b, Pin_c, Pin_d, Pin_e, Pin_f, Pin_g, Pin_dp, dig_sel_n,
    output digit_value, digit_dp, digit_valid, digit_err, update, update_idx
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Recovers hex digits from a multiplexed common-anode seven-segment drive.
// Pins are double-flop synchronized, a scan slot is accepted once the whole
// synchronized vector has been identical for STABLE_CYCLES samples, and the
// segment pattern is decoded into a per-digit register file.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    seg7_scan_decoder_if.slave (pins in, decoded digits out)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_WAIT  | no valid one-hot select seen; waiting for a scan slot
// ST_SETTLE| counting identical samples of the latched pattern
// ST_HOLD  | pattern captured; stays idle until the sampled vector changes
module seg7_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 8
) (
  input logic               clk,
  input logic               rst_n,
  seg7_scan_decoder_if.slave bus
);

  localparam int W  = 8 + DIGITS;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t              state_q;
  logic [W-1:0]        pins_d;
  logic [W-1:0]        sync1_q;
  logic [W-1:0]        s_q;
  logic [W-1:0]        pat_q;
  logic [IW-1:0]       idx_q;
  logic [CW-1:0]       cnt_q;
  logic [4*DIGITS-1:0] value_q;
  logic [DIGITS-1:0]   dp_q;
  logic [DIGITS-1:0]   valid_q;
  logic [DIGITS-1:0]   err_q;
  logic                update_q;
  logic [2:0]          update_idx_q;

  logic [3:0]          n_low;
  logic [IW-1:0]       s_idx;
  logic                s_onehot;
  logic [4:0]          dec;

  // {err, value}; any non-glyph lit pattern decodes to err with value 0
  function automatic logic [4:0] decode(input logic [6:0] lit);
    case (lit)
      7'h7E:   decode = 5'h00;
      7'h30:   decode = 5'h01;
      7'h6D:   decode = 5'h02;
      7'h79:   decode = 5'h03;
      7'h33:   decode = 5'h04;
      7'h5B:   decode = 5'h05;
      7'h5F:   decode = 5'h06;
      7'h70:   decode = 5'h07;
      7'h7F:   decode = 5'h08;
      7'h7B:   decode = 5'h09;
      7'h77:   decode = 5'h0A;
      7'h1F:   decode = 5'h0B;
      7'h4E:   decode = 5'h0C;
      7'h3D:   decode = 5'h0D;
      7'h4F:   decode = 5'h0E;
      7'h47:   decode = 5'h0F;
      default: decode = 5'h10;
    endcase
  endfunction

  assign pins_d = {bus.Pin_a, bus.Pin_b, bus.Pin_c, bus.Pin_d, bus.Pin_e,
                   bus.Pin_f, bus.Pin_g, bus.Pin_dp, bus.dig_sel_n};

  always_comb begin
    n_low = 4'd0;
    s_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!s_q[i]) begin
        n_low = n_low + 4'd1;
        s_idx = IW'(i);
      end
    end
  end

  assign s_onehot = (n_low == 4'd1);
  // segments a..g sit at the top of the vector and are active-low
  assign dec      = decode(~pat_q[W-1 -: 7]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      s_q          <= '0;
      state_q      <= ST_WAIT;
      pat_q        <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      value_q      <= '0;
      dp_q         <= '0;
      valid_q      <= '0;
      err_q        <= '0;
      update_q     <= 1'b0;
      update_idx_q <= 3'd0;
    end else begin
      sync1_q  <= pins_d;
      s_q      <= sync1_q;
      update_q <= 1'b0;
      // WAIT and any change of the sampled vector share one evaluation, so a
      // segment and select change on the same edge is a single restart.
      if (state_q == ST_WAIT || s_q != pat_q) begin
        if (s_onehot) begin
          pat_q   <= s_q;
          idx_q   <= s_idx;
          cnt_q   <= CW'(1);
          state_q <= ST_SETTLE;
        end else begin
          cnt_q   <= '0;
          state_q <= ST_WAIT;
        end
      end else if (state_q == ST_SETTLE) begin
        if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
          cnt_q                      <= CW'(STABLE_CYCLES);
          state_q                    <= ST_HOLD;
          value_q[{idx_q, 2'b00} +: 4] <= dec[3:0];
          err_q[idx_q]               <= dec[4];
          dp_q[idx_q]                <= ~pat_q[DIGITS];
          valid_q[idx_q]             <= 1'b1;
          update_q                   <= 1'b1;
          update_idx_q               <= 3'(idx_q);
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign bus.digit_value = value_q;
  assign bus.digit_dp    = dp_q;
  assign bus.digit_valid = valid_q;
  assign bus.digit_err   = err_q;
  assign bus.update      = update_q;
  assign bus.update_idx  = update_idx_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scenarios plus randomized scanning,
// every cycle compared against a history-based reference model.
module tb_seg7_scan_decoder;
  localparam int DIGITS = 4;
  localparam int STABLE = 8;
  localparam int W      = 8 + DIGITS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_decoder_if #(.DIGITS(DIGITS)) bus ();
  seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int upd_cnt = 0;

  logic [6:0] glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic [6:0] lit, input logic dp_lit, input logic [DIGITS-1:0] sel_n);
    {bus.Pin_a, bus.Pin_b, bus.Pin_c, bus.Pin_d, bus.Pin_e, bus.Pin_f, bus.Pin_g} = ~lit;
    bus.Pin_dp    = ~dp_lit;
    bus.dig_sel_n = sel_n;
  endtask

  function automatic logic [W-1:0] pins_now();
    return {bus.Pin_a, bus.Pin_b, bus.Pin_c, bus.Pin_d, bus.Pin_e, bus.Pin_f,
            bus.Pin_g, bus.Pin_dp, bus.dig_sel_n};
  endfunction

  // ---------------- reference model ----------------
  // The decoder looks at pins sampled two edges earlier; a capture happens on
  // the edge where a one-hot vector has been seen identically STABLE times.
  logic [W-1:0]        hist [$];
  logic [W-1:0]        seen, prev_seen;
  int                  run;
  logic [4*DIGITS-1:0] e_value;
  logic [DIGITS-1:0]   e_dp, e_valid, e_err;
  logic                e_upd;
  int                  e_idx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist = {};
      hist.push_back('0);
      hist.push_back('0);
      run       = 0;
      prev_seen = '0;
      e_value   = '0;
      e_dp      = '0;
      e_valid   = '0;
      e_err     = '0;
      e_upd     = 1'b0;
      e_idx     = 0;
    end else begin
      logic [DIGITS-1:0] sel_low;
      logic [6:0]        lit;
      int                k;
      int                v;
      seen = hist.pop_front();
      hist.push_back(pins_now());
      e_upd = 1'b0;
      run   = (seen == prev_seen) ? run + 1 : 1;
      prev_seen = seen;
      sel_low = ~seen[DIGITS-1:0];
      if ($countones(sel_low) == 1 && run == STABLE) begin
        k = 0;
        for (int i = 0; i < DIGITS; i++) if (sel_low[i]) k = i;
        lit = ~seen[W-1 -: 7];
        v = -1;
        for (int g = 0; g < 16; g++) if (glyph[g] == lit) v = g;
        e_value[4*k +: 4] = (v < 0) ? 4'd0 : 4'(v);
        e_err[k]   = (v < 0);
        e_dp[k]    = ~seen[DIGITS];
        e_valid[k] = 1'b1;
        e_upd      = 1'b1;
        e_idx      = k;
      end
    end
  end

  // ---------------- per-cycle monitor ----------------
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (bus.update) upd_cnt++;
      check("update", bus.update, e_upd);
      if (e_upd) check("update_idx", bus.update_idx, e_idx);
      check("digit_value", bus.digit_value, e_value);
      check("digit_dp", bus.digit_dp, e_dp);
      check("digit_valid", bus.digit_valid, e_valid);
      check("digit_err", bus.digit_err, e_err);
    end
  end

  task automatic wait_update(input int max_edges, output int edge_idx);
    edge_idx = -1;
    for (int i = 0; i < max_edges; i++) begin
      @(posedge clk);
      #1;
      if (bus.update) begin
        edge_idx = i;
        return;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_value"}, bus.digit_value, 0);
    check({tag, "_dp"}, bus.digit_dp, 0);
    check({tag, "_valid"}, bus.digit_valid, 0);
    check({tag, "_err"}, bus.digit_err, 0);
    check({tag, "_update"}, bus.update, 0);
    check({tag, "_update_idx"}, bus.update_idx, 0);
  endtask

  initial begin
    int u0;
    int e;
    drive(7'h00, 1'b0, 4'b1111);

    // reset, then idle with no digit selected
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    u0 = upd_cnt;
    repeat (100) @(negedge clk);
    check("idle_updates", upd_cnt - u0, 0);
    check_all_zero("idle");

    // single digit, latency to the 10th edge
    u0 = upd_cnt;
    drive(7'h5B, 1'b1, 4'b1110);
    wait_update(20, e);
    check("latency_d0", e, 9);
    check("idx_d0", bus.update_idx, 0);
    check("value_d0", bus.digit_value[3:0], 5);
    check("dp_d0", bus.digit_dp[0], 1);
    check("valid_d0", bus.digit_valid[0], 1);
    check("err_d0", bus.digit_err[0], 0);
    @(negedge clk);
    repeat (10) @(negedge clk);
    check("single_update", upd_cnt - u0, 1);

    // scan 1,2,3,4 over digits 0..3 twice
    u0 = upd_cnt;
    for (int r = 0; r < 2; r++) begin
      for (int d = 0; d < DIGITS; d++) begin
        drive(glyph[d + 1], 1'b0, ~(DIGITS'(1) << d));
        repeat (16) @(negedge clk);
      end
    end
    check("scan_updates", upd_cnt - u0, 8);
    check("scan_value", bus.digit_value, 16'h4321);
    check("scan_valid", bus.digit_valid, 4'hF);

    // one-cycle glitch on segment g restarts the settle count
    u0 = upd_cnt;
    drive(7'h5B, 1'b0, 4'b1110);
    repeat (5) @(negedge clk);
    drive(7'h5A, 1'b0, 4'b1110);
    @(negedge clk);
    check("glitch_no_early", upd_cnt - u0, 0);
    drive(7'h5B, 1'b0, 4'b1110);
    wait_update(20, e);
    check("glitch_latency", e, 9);
    @(negedge clk);
    repeat (10) @(negedge clk);
    check("glitch_updates", upd_cnt - u0, 1);
    check("glitch_value", bus.digit_value[3:0], 5);

    // non-glyph "H" on digit 2, then an invalid two-hot select
    drive(7'h37, 1'b0, 4'b1011);
    wait_update(20, e);
    check("h_latency", e, 9);
    check("h_idx", bus.update_idx, 2);
    check("h_err", bus.digit_err[2], 1);
    check("h_value", bus.digit_value[11:8], 0);
    check("h_valid", bus.digit_valid[2], 1);
    @(negedge clk);
    repeat (5) @(negedge clk);
    u0 = upd_cnt;
    drive(glyph[7], 1'b0, 4'b1100);
    repeat (30) @(negedge clk);
    check("twohot_updates", upd_cnt - u0, 0);

    // reset in mid-settle (cnt=5) clears everything; full settle afterwards
    u0 = upd_cnt;
    drive(7'h79, 1'b1, 4'b1101);
    repeat (7) @(negedge clk);
    check("pre_reset_updates", upd_cnt - u0, 0);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    wait_update(20, e);
    check("post_reset_latency", e, 9);
    check("post_reset_idx", bus.update_idx, 1);
    check("post_reset_value", bus.digit_value, 16'h0030);
    @(negedge clk);

    // randomized scanning against the model
    for (int it = 0; it < 250; it++) begin
      int               r;
      logic [DIGITS-1:0] sel;
      logic [6:0]       lit;
      logic [31:0]      rnd;
      r = $urandom_range(0, 9);
      rnd = $urandom;
      if (r < 8)       sel = ~(DIGITS'(1) << $urandom_range(0, DIGITS - 1));
      else if (r == 8) sel = 4'b1111;
      else             sel = rnd[DIGITS-1:0];
      if ($urandom_range(0, 3) == 0) lit = rnd[10:4];
      else                           lit = glyph[$urandom_range(0, 15)];
      drive(lit, rnd[12], sel);
      repeat ($urandom_range(1, 14)) @(negedge clk);
    end
    repeat (12) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
